// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator with programmable geometry and four built-in test patterns.
// Outputs are registered one clock behind the pixel/line counters.
module lcd_timing_gen #(
  parameter int unsigned H_PERIOD = 429,
  parameter int unsigned H_PWIDTH = 11,
  parameter int unsigned H_BPORCH = 42,
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_PERIOD = 262,
  parameter int unsigned V_PWIDTH = 3,
  parameter int unsigned V_BPORCH = 7,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned CW       = 6
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] fg,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic [9:0]      x,
  output logic [9:0]      y,
  output logic            frame_start
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 3 * CW;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_PERIOD - 1);
  localparam logic [CNT_W-1:0] H_SYNC    = CNT_W'(H_PWIDTH);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_SYNC    = CNT_W'(V_PWIDTH);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_BPORCH + V_ACTIVE);
  localparam logic [CNT_W-1:0] BAR_W     = CNT_W'(H_ACTIVE / 8);
  localparam logic [CW-1:0]    FULL      = {CW{1'b1}};

  logic [CNT_W-1:0] p_q, p_d, l_q, l_d;
  logic [1:0]       mode_q, mode_d;
  logic [RGB_W-1:0] fg_q, fg_d;

  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [CW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  logic             origin;
  logic             active;
  logic [CNT_W-1:0] x_pix, y_pix, bar_num;
  logic [2:0]       bar_idx, bar_mask;

  // Counter advance and pattern latch; the pattern is sampled only at the frame origin
  always_comb begin
    p_d    = '0;
    l_d    = '0;
    mode_d = mode_q;
    fg_d   = fg_q;
    origin = (p_q == '0) && (l_q == '0);
    if (en) begin
      if (p_q == H_LAST) begin
        p_d = '0;
        l_d = (l_q == V_LAST) ? '0 : l_q + 10'd1;
      end else begin
        p_d = p_q + 10'd1;
        l_d = l_q;
      end
      if (origin) begin
        mode_d = mode;
        fg_d   = fg;
      end
    end
  end

  // Decode current counter state into the next registered outputs
  always_comb begin
    active   = (p_q >= H_ACT_BEG) && (p_q < H_ACT_END) &&
               (l_q >= V_ACT_BEG) && (l_q < V_ACT_END);
    x_pix    = p_q - H_ACT_BEG;
    y_pix    = l_q - V_ACT_BEG;
    bar_num  = x_pix / BAR_W;
    bar_idx  = (bar_num > 10'd7) ? 3'd7 : bar_num[2:0];
    bar_mask = 3'b000;
    case (bar_idx)
      3'd0: bar_mask = 3'b111;
      3'd1: bar_mask = 3'b110;
      3'd2: bar_mask = 3'b011;
      3'd3: bar_mask = 3'b010;
      3'd4: bar_mask = 3'b101;
      3'd5: bar_mask = 3'b100;
      3'd6: bar_mask = 3'b001;
      3'd7: bar_mask = 3'b000;
    endcase

    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (en) begin
      hsync_d = !(p_q < H_SYNC);
      vsync_d = !(l_q < V_SYNC);
      fs_d    = origin;
      if (active) begin
        de_d = 1'b1;
        x_d  = x_pix;
        y_d  = y_pix;
        case (mode_d)
          2'd0: begin
            r_d = bar_mask[2] ? FULL : '0;
            g_d = bar_mask[1] ? FULL : '0;
            b_d = bar_mask[0] ? FULL : '0;
          end
          2'd1: begin
            r_d = fg_d[3*CW-1:2*CW];
            g_d = fg_d[2*CW-1:CW];
            b_d = fg_d[CW-1:0];
          end
          2'd2: begin
            r_d = (x_pix[4] ^ y_pix[4]) ? FULL : '0;
            g_d = r_d;
            b_d = r_d;
          end
          2'd3: begin
            r_d = x_pix[CW-1:0];
            g_d = x_pix[CW-1:0];
            b_d = x_pix[CW-1:0];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      p_q     <= '0;
      l_q     <= '0;
      mode_q  <= '0;
      fg_q    <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      p_q     <= p_d;
      l_q     <= l_d;
      mode_q  <= mode_d;
      fg_q    <= fg_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: frame-level model checked every clock, plus literal
// pixel and geometry expectations. Vertical geometry is shortened to keep runs small.
module tb_lcd_timing_gen;

  localparam int HP = 429, HW = 11, HB = 42, HA = 320;
  localparam int VP = 28, VW = 3, VB = 7, VA = 18;
  localparam int CW = 6;
  localparam int FULL = (1 << CW) - 1;
  localparam int FRAME = HP * VP;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          en = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [3*CW-1:0] fg = '0;
  logic          hsync, vsync, de, frame_start;
  logic [CW-1:0] r, g, b;
  logic [9:0]    x, y;

  lcd_timing_gen #(
    .H_PERIOD(HP), .H_PWIDTH(HW), .H_BPORCH(HB), .H_ACTIVE(HA),
    .V_PERIOD(VP), .V_PWIDTH(VW), .V_BPORCH(VB), .V_ACTIVE(VA), .CW(CW)
  ) dut (
    .clk(clk), .res_n(res_n), .en(en), .mode(mode), .fg(fg),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .x(x), .y(y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: position in the frame and the pattern latched for this frame
  int mp = 0, ml = 0, mmode = 0, mfg = 0, fidx = -1;
  int e_hs, e_vs, e_de, e_fs, e_x, e_y, e_r, e_g, e_b;
  int bar_colors[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  // Geometry measurement state
  bit geo_en = 1'b1;
  int cyc = 0, hs_run = 0, hs_fall = -1, vs_run = 0, de_run = 0, de_runs = 0;
  int last_fs = -1, max_x = 0, max_y = 0;
  logic prev_hs = 1'b1;

  function automatic int rgb_pack(input int rr, input int gg, input int bb);
    return (rr << 2*CW) | (gg << CW) | bb;
  endfunction

  always @(posedge clk) begin
    e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0;
    if (!res_n) begin
      mp = 0; ml = 0; mmode = 0; mfg = 0;
    end else if (!en) begin
      mp = 0; ml = 0;
    end else begin
      if (mp == 0 && ml == 0) begin
        mmode = int'(mode);
        mfg   = int'(fg);
      end
      e_hs = (mp < HW) ? 0 : 1;
      e_vs = (ml < VW) ? 0 : 1;
      e_fs = (mp == 0 && ml == 0) ? 1 : 0;
      if (mp >= HB && mp < HB + HA && ml >= VB && ml < VB + VA) begin
        int bar;
        e_de = 1;
        e_x  = mp - HB;
        e_y  = ml - VB;
        case (mmode)
          0: begin
            bar = e_x / (HA / 8);
            if (bar > 7) bar = 7;
            e_r = bar_colors[bar][2] ? FULL : 0;
            e_g = bar_colors[bar][1] ? FULL : 0;
            e_b = bar_colors[bar][0] ? FULL : 0;
          end
          1: begin
            e_r = (mfg >> 2*CW) & FULL;
            e_g = (mfg >> CW) & FULL;
            e_b = mfg & FULL;
          end
          2: begin
            e_r = (((e_x / 16) + (e_y / 16)) % 2 == 1) ? FULL : 0;
            e_g = e_r;
            e_b = e_r;
          end
          default: begin
            e_r = e_x % (1 << CW);
            e_g = e_r;
            e_b = e_r;
          end
        endcase
      end
      mp = mp + 1;
      if (mp == HP) begin
        mp = 0;
        ml = (ml == VP - 1) ? 0 : ml + 1;
      end
    end
    if (e_fs == 1) fidx++;
    #1;
    chk("sync_flags", {hsync, vsync, de, frame_start}, {e_hs[0], e_vs[0], e_de[0], e_fs[0]});
    chk("x", int'(x), e_x);
    chk("y", int'(y), e_y);
    chk("rgb", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(e_r, e_g, e_b));

    // Literal pixel expectations per scheduled frame pattern
    if (e_de == 1) begin
      case (fidx)
        0: begin
          if (e_y == 5 && e_x == 0)   chk("bars_x0",   rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(63, 63, 63));
          if (e_y == 5 && e_x == 40)  chk("bars_x40",  rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(63, 63, 0));
          if (e_y == 5 && e_x == 130) chk("bars_x130", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(0, 63, 0));
          if (e_y == 5 && e_x == 319) chk("bars_x319", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(0, 0, 0));
          if (e_y == VA - 1 && e_x == 0) chk("latch_hold_bars", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(63, 63, 63));
        end
        1: if (e_y == 5 && e_x == 5) chk("solid_fg", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(10, 20, 30));
        2: begin
          if (e_y == 0 && e_x == 15)  chk("checker_15_0",  rgb_pack(int'(r), int'(g), int'(b)), 0);
          if (e_y == 0 && e_x == 16)  chk("checker_16_0",  rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(63, 63, 63));
          if (e_y == 16 && e_x == 16) chk("checker_16_16", rgb_pack(int'(r), int'(g), int'(b)), 0);
        end
        3: if (e_y == 5 && e_x == 70) chk("ramp_x70", rgb_pack(int'(r), int'(g), int'(b)), rgb_pack(6, 6, 6));
        default: ;
      endcase
    end

    // Sync and data-enable geometry over the undisturbed frames
    cyc++;
    if (geo_en) begin
      if (!hsync) hs_run++;
      else begin
        if (hs_run != 0) chk("hsync_width", hs_run, HW);
        hs_run = 0;
      end
      if (!hsync && prev_hs) begin
        if (hs_fall >= 0) chk("hsync_period", cyc - hs_fall, HP);
        hs_fall = cyc;
      end
      if (!vsync) vs_run++;
      else begin
        if (vs_run != 0) chk("vsync_width", vs_run, VW * HP);
        vs_run = 0;
      end
      if (de) begin
        de_run++;
        if (int'(x) > max_x) max_x = int'(x);
        if (int'(y) > max_y) max_y = int'(y);
      end else begin
        if (de_run != 0) begin
          chk("de_run_len", de_run, HA);
          de_runs++;
        end
        de_run = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          chk("frame_period", cyc - last_fs, FRAME);
          chk("de_runs_per_frame", de_runs, VA);
        end
        last_fs = cyc;
        de_runs = 0;
      end
    end
    prev_hs = hsync;
  end

  task automatic wait_fs(input string nm, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #2;
      if (frame_start) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  initial begin
    res_n = 1'b0;
    en    = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("reset_idle", {hsync, vsync, de, frame_start}, 4'b1100);
    chk("reset_rgbxy", int'({r, g, b, x, y}), 0);

    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #2;
    chk("first_frame_start", {hsync, vsync, frame_start}, 3'b001);

    // Switch patterns at line 15 of each frame; each takes effect on the next frame
    repeat (15 * HP - 1) @(negedge clk);
    mode = 2'd1;
    fg   = {6'd10, 6'd20, 6'd30};
    repeat (FRAME) @(negedge clk);
    mode = 2'd2;
    repeat (FRAME) @(negedge clk);
    mode = 2'd3;
    repeat (FRAME + 100) @(negedge clk);

    // Drop enable mid-line
    geo_en = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #2;
    chk("en_idle_flags", {hsync, vsync, de, frame_start}, 4'b1100);
    chk("en_idle_xy", int'({x, y}), 0);
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_fs("en_restart_fs", 4);
    repeat (3000) @(negedge clk);

    // One-clock reset pulse mid-frame
    res_n = 1'b0;
    @(posedge clk);
    #2;
    chk("reset_pulse_idle", {hsync, vsync, de, frame_start}, 4'b1100);
    @(negedge clk);
    res_n = 1'b1;
    wait_fs("reset_restart_fs", 4);
    repeat (3000) @(negedge clk);

    chk("x_max", max_x, HA - 1);
    chk("y_max", max_y, VA - 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
